// File: rtl/led_pkg.sv
// Shared definitions for the LED controller: channel modes and channel-index width.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_OFF   = 2'd0;
  localparam led_mode_t LED_ON    = 2'd1;
  localparam led_mode_t LED_BLINK = 2'd2;
  localparam led_mode_t LED_PWM   = 2'd3;

  // A single channel still needs a one-bit select port.
  function automatic int ch_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable generator: one-cycle pulse every CLK_HZ/TICK_HZ clocks.
// clr_i restarts the count so the next pulse lands a full period later.
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_reg;
  logic             tick_next;

  always_comb begin
    cnt_next  = cnt_reg + 1'b1;
    tick_next = 1'b0;
    if (cnt_reg == CNT_LAST) begin
      cnt_next  = '0;
      tick_next = 1'b1;
    end
    if (clr_i) begin
      cnt_next  = '0;
      tick_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= tick_next;
    end
  end

  assign tick_o = tick_reg;

endmodule

// File: rtl/led_ctrl.sv
// N-channel LED controller (OFF/ON/BLINK/PWM) driven from a shared tick enable.
// Channel 0 can come out of reset blinking as a board heartbeat.
module led_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int N_CH       = 4,
  parameter int PER_W      = 16,
  parameter int PWM_W      = 8,
  parameter int RST_BLINK0 = 1,
  parameter int RST_PER    = 500
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_we_i,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [PER_W-1:0]        cfg_period_i,
  input  logic [PWM_W-1:0]        cfg_duty_i,
  input  logic                    sync_i,
  output logic                    tick_o,
  output logic [N_CH-1:0]         led_o
);

  localparam int CH_W = ch_w(N_CH);

  logic             tick_raw;
  logic             tick;
  logic [PWM_W-1:0] pwm_cnt_reg;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (sync_i),
    .tick_o (tick_raw)
  );

  // A sync cycle never carries a tick, so phases restart cleanly.
  assign tick   = tick_raw & ~sync_i;
  assign tick_o = tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam bit                IS_HB      = (gi == 0) && (RST_BLINK0 != 0);
    localparam led_mode_t         RST_MODE   = IS_HB ? LED_BLINK : LED_OFF;
    localparam logic [PER_W-1:0]  RST_PERIOD = IS_HB ? PER_W'(RST_PER) : '0;
    localparam logic              RST_STATE  = IS_HB;

    led_mode_t        mode_reg;
    led_mode_t        mode_next;
    logic [PER_W-1:0] period_reg;
    logic [PER_W-1:0] period_next;
    logic [PER_W-1:0] phase_reg;
    logic [PER_W-1:0] phase_next;
    logic [PER_W-1:0] phase_last;
    logic [PWM_W-1:0] duty_reg;
    logic [PWM_W-1:0] duty_next;
    logic             state_reg;
    logic             state_next;
    logic             led_reg;
    logic             led_next;
    logic             wr_hit;

    // Out-of-range channel indices simply never match any channel.
    assign wr_hit     = cfg_we_i && (cfg_ch_i == CH_W'(gi));
    assign phase_last = (period_reg == '0) ? '0 : period_reg - 1'b1;

    always_comb begin
      mode_next   = mode_reg;
      period_next = period_reg;
      duty_next   = duty_reg;
      phase_next  = phase_reg;
      state_next  = state_reg;
      led_next    = 1'b0;

      if (tick) begin
        if (phase_reg == phase_last) begin
          phase_next = '0;
          state_next = ~state_reg;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      if (sync_i) begin
        phase_next = '0;
        state_next = 1'b1;
      end

      // A write overrides any tick or sync in the same cycle.
      if (wr_hit) begin
        mode_next   = cfg_mode_i;
        period_next = cfg_period_i;
        duty_next   = cfg_duty_i;
        phase_next  = '0;
        state_next  = 1'b1;
      end

      case (mode_reg)
        LED_OFF:   led_next = 1'b0;
        LED_ON:    led_next = 1'b1;
        LED_BLINK: led_next = state_reg;
        default:   led_next = (pwm_cnt_reg < duty_reg);
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mode_reg   <= RST_MODE;
        period_reg <= RST_PERIOD;
        duty_reg   <= '0;
        phase_reg  <= '0;
        state_reg  <= RST_STATE;
        led_reg    <= 1'b0;
      end else begin
        mode_reg   <= mode_next;
        period_reg <= period_next;
        duty_reg   <= duty_next;
        phase_reg  <= phase_next;
        state_reg  <= state_next;
        led_reg    <= led_next;
      end
    end

    assign led_o[gi] = led_reg;
  end

endmodule
